// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: memory access kind, atomic result, LL/SC monitor state.
package mips_core_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } MemAccessType;

    typedef enum logic [1:0] {
        NOT_ATOMIC  = 2'd0,
        ATOMIC_FAIL = 2'd1,
        ATOMIC_PASS = 2'd2
    } AtomicStatus;

    typedef enum logic [1:0] {
        LLSC_IDLE      = 2'd0,
        LLSC_ARMED     = 2'd1,
        LLSC_SC_COMMIT = 2'd2
    } LlscState;

endpackage

// File: rtl/llsc_timeout_counter.sv
// Reservation lifetime counter; only built when LLSC_TIMEOUT_EN is defined.
// Counts while enabled, zeroes on clear, flags the last cycle of the lifetime.
`ifdef LLSC_TIMEOUT_EN
module llsc_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Age counter: restart on a new LL, advance only while the reservation is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire_c = enable & ~clear & (cnt == LAST);

endmodule
`endif

// File: rtl/llsc_reservation_unit.sv
// LL/SC reservation monitor for the MEM stage: holds one granule reservation,
// gates SC writes to the d-cache and reports the atomic result to writeback.
// Optional reservation timeout: define LLSC_TIMEOUT_EN.
module llsc_reservation_unit
    import mips_core_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned GRANULE_BITS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  MemAccessType                       req_type,
    input  logic                               req_ll,
    input  logic                               req_sc,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic                               cache_ready,
    output logic                               cache_wr_en,
    input  logic                               cache_wr_done,
    input  logic                               inv_valid,
    input  logic [ADDR_WIDTH-1:0]              inv_addr,
    output logic                               status_valid,
    output AtomicStatus                        atomic_status,
    output logic [31:0]                        sc_result,
    output logic                               rsv_valid,
    output logic [ADDR_WIDTH-GRANULE_BITS-1:0] rsv_granule
);

    localparam int unsigned GW = ADDR_WIDTH - GRANULE_BITS;

    LlscState       state;
    logic           accept;
    logic           ll_acc;
    logic           sc_acc;
    logic           wr_acc;
    logic           sc_pass;
    logic           req_match;
    logic           inv_match;
    logic           rsv_clear;
    logic           timeout_expire;
    logic [GW-1:0]  req_granule;
    logic [GW-1:0]  inv_granule;
    logic           unused_bits;

    assign req_granule = req_addr[ADDR_WIDTH-1:GRANULE_BITS];
    assign inv_granule = inv_addr[ADDR_WIDTH-1:GRANULE_BITS];
    assign unused_bits = ^{req_addr[GRANULE_BITS-1:0], inv_addr[GRANULE_BITS-1:0], 32'(TIMEOUT_CYCLES)};

    // Request handshake and operation decode
    always_comb begin
        req_ready   = (state != LLSC_SC_COMMIT);
        accept      = req_valid & req_ready & cache_ready & ~flush;
        ll_acc      = accept & req_ll & (req_type == READ);
        sc_acc      = accept & req_sc & (req_type == WRITE);
        wr_acc      = accept & ~req_sc & (req_type == WRITE);
        req_match   = (req_granule == rsv_granule);
        inv_match   = inv_valid & (inv_granule == rsv_granule);
        sc_pass     = sc_acc & (state == LLSC_ARMED) & req_match & ~inv_match;
        cache_wr_en = sc_pass | wr_acc;
        rsv_clear   = (state == LLSC_ARMED) & ((wr_acc & req_match) | inv_match | timeout_expire);
    end

`ifdef LLSC_TIMEOUT_EN
    llsc_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (state == LLSC_ARMED),
        .clear    (ll_acc),
        .expire_c (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    // Reservation FSM: a pending SC commit finishes ahead of flush; flush beats LL/SC;
    // an SC is judged before any same-cycle timeout or conflict clears the reservation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LLSC_IDLE;
            rsv_valid     <= 1'b0;
            rsv_granule   <= '0;
            status_valid  <= 1'b0;
            atomic_status <= NOT_ATOMIC;
            sc_result     <= '0;
        end else begin
            status_valid <= 1'b0;
            if (state == LLSC_SC_COMMIT) begin
                if (cache_wr_done) begin
                    state         <= LLSC_IDLE;
                    status_valid  <= 1'b1;
                    atomic_status <= ATOMIC_PASS;
                    sc_result     <= 32'd1;
                end
            end else if (flush) begin
                state     <= LLSC_IDLE;
                rsv_valid <= 1'b0;
            end else if (ll_acc) begin
                state       <= LLSC_ARMED;
                rsv_valid   <= 1'b1;
                rsv_granule <= req_granule;
            end else if (sc_acc) begin
                rsv_valid <= 1'b0;
                if (sc_pass) begin
                    state <= LLSC_SC_COMMIT;
                end else begin
                    state         <= LLSC_IDLE;
                    status_valid  <= 1'b1;
                    atomic_status <= ATOMIC_FAIL;
                    sc_result     <= 32'd0;
                end
            end else if (rsv_clear) begin
                state     <= LLSC_IDLE;
                rsv_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/llsc_reservation_unit.md
Name: llsc_reservation_unit

Overview:
- Load-linked/store-conditional reservation monitor in the MEM stage, between the MEM pipeline register and the d-cache request port.
- Holds one address reservation set by LL, checks it on SC, and gates the SC write to the cache.
- Reports an AtomicStatus result and the rt writeback value (1/0) to the writeback stage.
- Clears the reservation on coherent invalidations, conflicting stores and pipeline flushes.

Parameters:
ADDR_WIDTH, 32, byte-address width
GRANULE_BITS, 4, log2 of reservation granule in bytes; compare uses addr[ADDR_WIDTH-1:GRANULE_BITS]
TIMEOUT_CYCLES, 1024, reservation lifetime in cycles; used only with LLSC_TIMEOUT_EN

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  squash MEM-stage instruction and clear reservation (exception/eret)
req_valid  input  1  MEM stage presents a memory op
req_ready  output  1  unit can accept a request (low while SC commit is pending)
req_type  input  MemAccessType  READ or WRITE
req_ll  input  1  op is LL (req_type==READ)
req_sc  input  1  op is SC (req_type==WRITE)
req_addr  input  ADDR_WIDTH  byte address
cache_ready  input  1  d-cache accepts a request this cycle
cache_wr_en  output  1  gated write enable to d-cache
cache_wr_done  input  1  d-cache write completed (one-cycle pulse)
inv_valid  input  1  external invalidation (DMA/other master)
inv_addr  input  ADDR_WIDTH  invalidated address
status_valid  output  1  one-cycle pulse: atomic_status and sc_result are valid
atomic_status  output  AtomicStatus  NOT_ATOMIC / ATOMIC_FAIL / ATOMIC_PASS
sc_result  output  32  SC rt writeback value: 1 pass, 0 fail
rsv_valid  output  1  reservation held
rsv_granule  output  ADDR_WIDTH-GRANULE_BITS  reserved granule

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, rsv_valid 0, rsv_granule 0, status_valid 0, atomic_status NOT_ATOMIC, sc_result 0.
- Accept condition: accept = req_valid & req_ready & cache_ready & !flush.
- FSM states (LlscState): LLSC_IDLE, LLSC_ARMED, LLSC_SC_COMMIT. req_ready = (state != LLSC_SC_COMMIT).
- LL accepted: rsv_granule <= granule(req_addr); state <= LLSC_ARMED. An existing reservation is overwritten.
- SC accepted, pass condition: state==LLSC_ARMED, granule match, and no same-cycle matching inv_valid.
  - cache_wr_en=1 combinationally.
  - Reservation cleared; state <= LLSC_SC_COMMIT.
  - On cache_wr_done: pulse status_valid next cycle with ATOMIC_PASS and sc_result=1; state <= LLSC_IDLE.
- SC accepted, fail: cache_wr_en=0; state <= LLSC_IDLE; next cycle status_valid=1, ATOMIC_FAIL, sc_result=0.
- Plain WRITE accepted: cache_wr_en=1. If its granule matches the reservation, the reservation clears.
- Plain READ: no effect on the reservation. No status pulse for non-SC ops.
- inv_valid with matching granule clears the reservation (ARMED -> IDLE). In LLSC_SC_COMMIT the write is already committed; invalidation is ignored.
- Simultaneous events:
  - LL + matching inv same cycle: LL wins, reservation set.
  - flush: no accept, cache_wr_en=0, reservation cleared. flush has priority over everything except LLSC_SC_COMMIT, which completes normally.
- cache_wr_en is never asserted without accept.
- Reset mid-commit: return to IDLE, no status pulse.
- Granule compare uses the upper ADDR_WIDTH-GRANULE_BITS bits only.

Optional Feature:
- LLSC_TIMEOUT_EN defined:
  - Counter of width $clog2(TIMEOUT_CYCLES) runs only in LLSC_ARMED; it zeroes on every LL accept.
  - When it reaches TIMEOUT_CYCLES-1, the reservation clears next edge (ARMED -> IDLE), so a later SC fails.
  - Timeout and an SC accept in the same cycle: SC is evaluated first with the reservation still valid.
- Not defined: no counter; the reservation persists until LL overwrite, SC, conflicting store, invalidation, flush or reset.

Decomposition:
- mips_core_pkg gains the LlscState enum (2-bit: LLSC_IDLE, LLSC_ARMED, LLSC_SC_COMMIT).
- It reuses the existing MemAccessType and AtomicStatus.
- One natural sub-module: llsc_timeout_counter (enable, clear, expire pulse), instantiated only under LLSC_TIMEOUT_EN.

Test Plan:
- LL 0x1000, then SC 0x1008 (same 16B granule), cache_wr_done 2 cycles later -> cache_wr_en=1 on accept; req_ready low until done; status_valid pulse ATOMIC_PASS, sc_result=1.
- LL 0x1000, inv_valid 0x100C, SC 0x1000 -> cache_wr_en=0; ATOMIC_FAIL, sc_result=0 one cycle after accept.
- LL 0x2000, plain WRITE 0x2004, SC 0x2000 -> fail. Repeat with WRITE 0x3000 -> SC passes.
- LL 0x4000 and flush in the same cycle -> rsv_valid stays 0; following SC 0x4000 fails, no cache write.
- SC with no prior LL; SC with cache_ready=0 for 3 cycles -> no accept while cache_ready low; then fail with no write. Also LL + matching inv same cycle -> rsv_valid=1.
- LLSC_TIMEOUT_EN, TIMEOUT_CYCLES=8: LL 0x5000, idle 8 cycles, SC -> ATOMIC_FAIL. Same with SC after 7 idle cycles -> ATOMIC_PASS.
